// File: rtl/piso_drain.sv
// piso_drain: sequences the 8-byte output PISO through one load and seven
// shifts per START. It captures the serial bytes into a circular FIFO and
// presents them to the host read port in first-word-fall-through order.
module piso_drain #(
   parameter int DEPTH = 16
) (
   input  logic                   CLKEXT,
   input  logic                   CLR_PISO_DRAIN,
   input  logic                   START,
   input  logic [7:0]             PISO_DATA,
   output logic                   EN_PISO_OUT,
   output logic                   SHIFT_OUT,
   input  logic                   RD,
   output logic [7:0]             RD_DATA,
   output logic                   EMPTY,
   output logic [$clog2(DEPTH):0] COUNT,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   DROP
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // A frame is accepted only while at least eight slots are free.
   localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - 8);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      k;
   logic [2:0]      k_nxt;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            room;
   logic            accept;
   logic            push;
   logic            pop;

   assign room   = (count <= FILL_LIMIT);
   assign accept = START && (state == S_IDLE) && room;
   // Every DRAIN cycle captures the byte currently on the PISO output.
   assign push   = (state == S_DRAIN);
   assign pop    = RD && (count != '0);

   // State register: sequencer state and drain index.
   always_ff @(posedge CLKEXT or posedge CLR_PISO_DRAIN) begin
      if (CLR_PISO_DRAIN) begin
         state <= S_IDLE;
         k     <= 3'd0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   // Next-state logic: load once, drain eight bytes, pulse done, return idle.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      case (state)
         S_IDLE: begin
            k_nxt = 3'd0;
            if (accept) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            state_nxt = S_DRAIN;
            k_nxt     = 3'd0;
         end
         S_DRAIN: begin
            if (k == 3'd7) begin
               state_nxt = S_DONE;
               k_nxt     = 3'd0;
            end else begin
               k_nxt = k + 3'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            k_nxt     = 3'd0;
         end
      endcase
   end

   // Output decode: PISO controls and status are pure functions of state and index.
   // The last drain cycle drops EN so the PISO holds data_7 while it is captured.
   always_comb begin
      EN_PISO_OUT = 1'b0;
      SHIFT_OUT   = 1'b0;
      BUSY        = (state != S_IDLE);
      DONE        = (state == S_DONE);
      case (state)
         S_LOAD: begin
            EN_PISO_OUT = 1'b1;
            SHIFT_OUT   = 1'b0;
         end
         S_DRAIN: begin
            EN_PISO_OUT = (k != 3'd7);
            SHIFT_OUT   = (k != 3'd7);
         end
         default: begin
            EN_PISO_OUT = 1'b0;
            SHIFT_OUT   = 1'b0;
         end
      endcase
   end

   // Sticky drop flag: any START that does not start a new frame is recorded.
   always_ff @(posedge CLKEXT or posedge CLR_PISO_DRAIN) begin
      if (CLR_PISO_DRAIN) begin
         DROP <= 1'b0;
      end else if (START && !accept) begin
         DROP <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge CLKEXT or posedge CLR_PISO_DRAIN) begin
      if (CLR_PISO_DRAIN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until the pointers make them visible.
   always_ff @(posedge CLKEXT) begin
      if (push) mem[wr_ptr] <= PISO_DATA;
   end

   assign EMPTY   = (count == '0);
   assign COUNT   = count;
   assign RD_DATA = EMPTY ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_piso_drain.sv
// Testbench for piso_drain: a behavioural PISO feeds the DUT. A per-cycle
// control trace table covers one frame; directed sequences cover fill/reject,
// start-during-frame, continuous reads, pointer wrap and mid-frame reset.
module tb_piso_drain;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rd;
   logic [7:0] piso_data;
   logic       en;
   logic       shift;
   logic [7:0] rd_data;
   logic       empty;
   logic [4:0] count;
   logic       busy;
   logic       done;
   logic       drop;

   int total = 0;
   int bad   = 0;

   logic [7:0] piso_in [8];
   logic [7:0] pr [8];
   logic [7:0] got [$];

   typedef struct {
      logic en;
      logic shift;
      logic busy;
      logic done;
      int   cnt;
   } trace_t;

   trace_t tr [10];

   always #5 clk = ~clk;

   piso_drain #(.DEPTH(DEPTH)) dut (
      .CLKEXT        (clk),
      .CLR_PISO_DRAIN(rst),
      .START         (start),
      .PISO_DATA     (piso_data),
      .EN_PISO_OUT   (en),
      .SHIFT_OUT     (shift),
      .RD            (rd),
      .RD_DATA       (rd_data),
      .EMPTY         (empty),
      .COUNT         (count),
      .BUSY          (busy),
      .DONE          (done),
      .DROP          (drop)
   );

   // Behavioural 8-byte PISO: parallel load when EN && !SHIFT, shift toward data_out when EN && SHIFT.
   always @(posedge clk) begin
      if (en) begin
         if (!shift) begin
            for (int j = 0; j < 8; j++) pr[j] <= piso_in[j];
         end else begin
            for (int j = 0; j < 7; j++) pr[j] <= pr[j+1];
            pr[7] <= 8'h00;
         end
      end
   end
   assign piso_data = pr[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_piso(input logic [7:0] base);
      for (int j = 0; j < 8; j++) piso_in[j] = base + 8'(j);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      rd    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Issue START and step to the first IDLE cycle after DONE.
   task automatic run_frame(input logic [7:0] base, input int off, input bit trace);
      set_piso(base);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (trace) begin
            chk($sformatf("trace_en_c%0d", i + 1), en, tr[i].en);
            chk($sformatf("trace_shift_c%0d", i + 1), shift, tr[i].shift);
            chk($sformatf("trace_busy_c%0d", i + 1), busy, tr[i].busy);
            chk($sformatf("trace_done_c%0d", i + 1), done, tr[i].done);
            chk($sformatf("trace_count_c%0d", i + 1), count, tr[i].cnt + off);
         end else if (i == 9) begin
            chk("frame_done", done, 1'b1);
            chk("frame_count", count, off + 8);
         end
         tick();
      end
      chk("frame_idle_after", busy, 1'b0);
   endtask

   task automatic read_byte(input logic [7:0] exp);
      chk("rd_not_empty", empty, 1'b0);
      chk("rd_data", rd_data, exp);
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Cycle n of the frame is observed just after edge E(n-1).
      //        en    shift busy  done  count
      tr[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};  // LOAD
      tr[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};  // DRAIN k=0
      tr[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};  // DRAIN k=1
      tr[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2};
      tr[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
      tr[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4};
      tr[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 5};
      tr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 6};  // DRAIN k=6
      tr[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 7};  // DRAIN k=7
      tr[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 8};  // DONE

      set_piso(8'h00);
      do_reset();

      // Reset values
      chk("rst_en", en, 1'b0);
      chk("rst_shift", shift, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_drop", drop, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_count", count, 5'd0);
      chk("rst_rd_data", rd_data, 8'h00);

      // Basic frame with full control trace, then drain in order
      run_frame(8'h10, 0, 1'b1);
      for (int j = 0; j < 8; j++) read_byte(8'h10 + 8'(j));
      chk("basic_empty", empty, 1'b1);
      chk("basic_rd_data_zero", rd_data, 8'h00);
      chk("basic_count_zero", count, 5'd0);
      chk("basic_no_drop", drop, 1'b0);

      // RD while empty changes nothing
      rd = 1'b1;
      tick();
      tick();
      rd = 1'b0;
      chk("rd_empty_count", count, 5'd0);
      chk("rd_empty_flag", empty, 1'b1);

      // Fill to DEPTH, reject a third frame, then accept after draining eight
      do_reset();
      run_frame(8'h80, 0, 1'b0);
      run_frame(8'h88, 8, 1'b0);
      chk("fill_count16", count, 5'd16);
      chk("fill_drop_before", drop, 1'b0);
      set_piso(8'hF0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("reject_drop", drop, 1'b1);
      chk("reject_busy", busy, 1'b0);
      chk("reject_count", count, 5'd16);
      tick();
      chk("reject_still_idle", busy, 1'b0);
      for (int j = 0; j < 8; j++) read_byte(8'h80 + 8'(j));
      chk("after_reads_count", count, 5'd8);
      run_frame(8'h90, 8, 1'b0);
      chk("refill_count16", count, 5'd16);
      for (int j = 0; j < 8; j++) read_byte(8'h88 + 8'(j));
      for (int j = 0; j < 8; j++) read_byte(8'h90 + 8'(j));
      chk("refill_empty", empty, 1'b1);

      // START during DRAIN is ignored and flagged
      do_reset();
      set_piso(8'hA0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      set_piso(8'h55);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("mid_start_drop", drop, 1'b1);
      chk("mid_start_busy", busy, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      chk("mid_start_idle", busy, 1'b0);
      chk("mid_start_count", count, 5'd8);
      for (int j = 0; j < 8; j++) read_byte(8'hA0 + 8'(j));
      chk("mid_start_empty", empty, 1'b1);

      // RD held high for a whole frame
      do_reset();
      rd = 1'b1;
      set_piso(8'h20);
      start = 1'b1;
      tick();
      start = 1'b0;
      got.delete();
      for (int i = 0; i < 14; i++) begin
         chk("rdhold_count_le1", (count <= 5'd1), 1'b1);
         if (!empty) got.push_back(rd_data);
         tick();
      end
      rd = 1'b0;
      chk("rdhold_nbytes", got.size(), 8);
      for (int j = 0; j < 8; j++) begin
         if (j < got.size()) chk($sformatf("rdhold_byte%0d", j), got[j], 8'h20 + 8'(j));
      end
      chk("rdhold_empty", empty, 1'b1);
      chk("rdhold_count", count, 5'd0);

      // Pointer wrap across several frames
      do_reset();
      for (int f = 0; f < 5; f++) begin
         run_frame(8'h40 + 8'(8 * f), 0, 1'b0);
         for (int j = 0; j < 8; j++) read_byte(8'h40 + 8'(8 * f + j));
      end
      chk("wrap_empty", empty, 1'b1);

      // Asynchronous reset in the middle of DRAIN (k=4)
      run_frame(8'h70, 0, 1'b0);
      do_reset();
      set_piso(8'hC0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_en", en, 1'b1);
      chk("pre_rst_count", count, 5'd4);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_en", en, 1'b0);
      chk("arst_shift", shift, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_count", count, 5'd0);
      chk("arst_empty", empty, 1'b1);
      chk("arst_rd_data", rd_data, 8'h00);
      chk("arst_drop", drop, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      run_frame(8'h60, 0, 1'b1);
      for (int j = 0; j < 8; j++) read_byte(8'h60 + 8'(j));
      chk("post_rst_empty", empty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
